// File: rtl/bcd_display_formatter_pkg.sv
// Shared definitions for the BCD display formatter: digit geometry, FSM encoding,
// double-dabble adjust constants and a small compile-time power-of-ten helper.
package bcd_display_formatter_pkg;

  localparam int DIGIT_BITS = 4;

  localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJUST_ADD       = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_UPDATE  = 2'd2
  } fmt_state_e;

  // 10^n as a 64-bit constant; used for the largest displayable value.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_display_formatter_if.sv
// Handshake and display-frame bundle between the value producer (master)
// and the formatter (slave).
interface bcd_display_formatter_if #(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
) ();

  logic [BIN_WIDTH-1:0]  in_value;
  logic [DIGITS-1:0]     in_dp;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     digit_enable;
  logic [DIGITS-1:0]     decimal_point_enable;
  logic                  overflow;
  logic                  out_valid;

  modport master (
    output in_value, in_dp, in_valid,
    input  in_ready, data, digit_enable, decimal_point_enable, overflow, out_valid
  );

  modport slave (
    input  in_value, in_dp, in_valid,
    output in_ready, data, digit_enable, decimal_point_enable, overflow, out_valid
  );

endinterface

// File: rtl/bcd_display_formatter_shift_add3_core.sv
// One double-dabble step: every BCD column >= 5 gets +3 (no inter-column carry,
// the adjusted digit is at most 12), then the whole accumulator shifts left by
// one with the next binary bit entering at the bottom.
module bcd_shift_add3_core
  import bcd_display_formatter_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  input  logic                msb_i,
  output logic [4*DIGITS-1:0] bcd_o
);

  logic [4*DIGITS-1:0] adj;

  // Per-column add-3 adjust followed by the one-bit shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[DIGIT_BITS*i +: DIGIT_BITS] >= BCD_ADJUST_THRESHOLD)
        adj[DIGIT_BITS*i +: DIGIT_BITS] = bcd_i[DIGIT_BITS*i +: DIGIT_BITS] + BCD_ADJUST_ADD;
      else
        adj[DIGIT_BITS*i +: DIGIT_BITS] = bcd_i[DIGIT_BITS*i +: DIGIT_BITS];
    end
    bcd_o = {adj[4*DIGITS-2:0], msb_i};
  end

endmodule

// File: rtl/bcd_display_formatter.sv
// Binary-to-BCD formatter feeding a 7-segment driver. Accepts one value per
// handshake, converts it serially (one bit per clock), then presents a stable
// frame of digits, digit enables and decimal points until the next conversion.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | in_ready high, waiting for a transfer; outputs hold
//   ST_CONVERT | BIN_WIDTH shift-add-3 steps, input ignored
//   ST_UPDATE  | load output frame, pulse out_valid, return to idle
module bcd_display_formatter
  import bcd_display_formatter_pkg::*;
#(
  parameter int BIN_WIDTH           = 20,
  parameter int DIGITS              = 6,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  bcd_display_formatter_if.slave   bus
);

  localparam int          CNT_W       = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_DISPLAY = pow10(DIGITS) - 64'd1;

  fmt_state_e             state_q;
  logic [BIN_WIDTH-1:0]   shift_q;
  logic [4*DIGITS-1:0]    bcd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DIGITS-1:0]      dp_q;
  logic                   ovf_cap_q;

  logic [4*DIGITS-1:0]    data_q;
  logic [DIGITS-1:0]      digit_enable_q;
  logic [DIGITS-1:0]      dp_enable_q;
  logic                   overflow_q;
  logic                   out_valid_q;
  logic                   in_ready_q;

  logic [4*DIGITS-1:0]    bcd_next;
  logic [4*DIGITS-1:0]    data_d;
  logic [DIGITS-1:0]      digit_enable_d;
  logic                   ovf_cap_d;

  bcd_shift_add3_core #(.DIGITS(DIGITS)) u_core (
    .bcd_i (bcd_q),
    .msb_i (shift_q[BIN_WIDTH-1]),
    .bcd_o (bcd_next)
  );

  // Values beyond the display range are flagged at capture time.
  assign ovf_cap_d = (64'(bus.in_value) > MAX_DISPLAY);

  // Output frame: saturate to all nines on overflow, otherwise blank leading
  // zeros while keeping digit 0 and anything up to the highest decimal point lit.
  always_comb begin
    logic keep;
    keep           = 1'b0;
    digit_enable_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      keep = keep | (|bcd_q[DIGIT_BITS*i +: DIGIT_BITS]) | dp_q[i];
      digit_enable_d[i] = keep | (i == 0);
    end
    if (!BLANK_LEADING_ZEROS) digit_enable_d = '1;
    data_d = bcd_q;
    if (ovf_cap_q) begin
      data_d         = {DIGITS{4'h9}};
      digit_enable_d = '1;
    end
  end

  // Sequencer, conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bcd_q          <= '0;
      cnt_q          <= '0;
      dp_q           <= '0;
      ovf_cap_q      <= 1'b0;
      data_q         <= '0;
      digit_enable_q <= '0;
      dp_enable_q    <= '0;
      overflow_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            shift_q    <= bus.in_value;
            dp_q       <= bus.in_dp;
            bcd_q      <= '0;
            cnt_q      <= CNT_W'(BIN_WIDTH);
            ovf_cap_q  <= ovf_cap_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          data_q         <= data_d;
          digit_enable_q <= digit_enable_d;
          dp_enable_q    <= dp_q;
          overflow_q     <= ovf_cap_q;
          out_valid_q    <= 1'b1;
          in_ready_q     <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready             = in_ready_q;
  assign bus.data                 = data_q;
  assign bus.digit_enable         = digit_enable_q;
  assign bus.decimal_point_enable = dp_enable_q;
  assign bus.overflow             = overflow_q;
  assign bus.out_valid            = out_valid_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench for bcd_display_formatter (DIGITS=6, BIN_WIDTH=20).
module tb_bcd_display_formatter;

  localparam int CLK_PERIOD = 4;
  localparam int LAT        = 21;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  bcd_display_formatter_if #(.BIN_WIDTH(20), .DIGITS(6)) bus ();

  bcd_display_formatter #(
    .BIN_WIDTH(20), .DIGITS(6), .BLANK_LEADING_ZEROS(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD/2) clk = ~clk;

  // Reference model: decimal digits by division, saturation above 999999.
  function automatic logic [23:0] model_data(input int unsigned v);
    logic [23:0] r;
    int unsigned p;
    r = '0;
    if (v > 999999) return 24'h999999;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_en(input int unsigned v, input logic [5:0] dp);
    int hi;
    int unsigned p;
    if (v > 999999) return 6'b111111;
    hi = 0;
    p  = 1;
    for (int i = 0; i < 6; i++) begin
      if (((v / p) % 10) != 0 || dp[i]) hi = i;
      p = p * 10;
    end
    return 6'((1 << (hi + 1)) - 1);
  endfunction

  // Drives one transfer and waits for out_valid; lat = cycles from the
  // transfer edge to the edge after which out_valid is seen, -1 on timeout.
  task automatic run_conv(input logic [19:0] v, input logic [5:0] dp, output int lat);
    lat = -1;
    for (int k = 0; k < 50 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    bus.in_value = v;
    bus.in_dp    = dp;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.data !== 24'h0) begin errors++; $display("FAIL reset_data got=%h exp=000000", bus.data); end
    checks++; if (bus.digit_enable !== 6'b0) begin errors++; $display("FAIL reset_en got=%b exp=000000", bus.digit_enable); end
    checks++; if (bus.decimal_point_enable !== 6'b0) begin errors++; $display("FAIL reset_dp got=%b exp=000000", bus.decimal_point_enable); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [19:0] tv [7];
    logic [5:0]  tdp[7];
    logic [23:0] xd [7];
    logic [5:0]  xe [7];
    logic        xo [7];
    int lat;
    tv = '{20'd123456, 20'd42, 20'd0, 20'd5,      20'd1048575, 20'd999999, 20'd1000000};
    tdp= '{6'b0,       6'b0,   6'b0,  6'b000100,  6'b0,        6'b0,       6'b000010};
    xd = '{24'h123456, 24'h000042, 24'h000000, 24'h000005, 24'h999999, 24'h999999, 24'h999999};
    xe = '{6'b111111,  6'b000011,  6'b000001,  6'b000111,  6'b111111,  6'b111111,  6'b111111};
    xo = '{1'b0,       1'b0,       1'b0,       1'b0,       1'b1,       1'b0,       1'b1};
    for (int i = 0; i < 7; i++) begin
      run_conv(tv[i], tdp[i], lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      checks++; if (bus.data !== xd[i]) begin errors++; $display("FAIL dir%0d_data got=%h exp=%h", i, bus.data, xd[i]); end
      checks++; if (bus.digit_enable !== xe[i]) begin errors++; $display("FAIL dir%0d_en got=%b exp=%b", i, bus.digit_enable, xe[i]); end
      checks++; if (bus.decimal_point_enable !== tdp[i]) begin errors++; $display("FAIL dir%0d_dp got=%b exp=%b", i, bus.decimal_point_enable, tdp[i]); end
      checks++; if (bus.overflow !== xo[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, bus.overflow, xo[i]); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.data !== xd[i]) begin
        errors++; $display("FAIL dir%0d_hold ov=%b data=%h exp ov=0 data=%h", i, bus.out_valid, bus.data, xd[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] v;
    logic [5:0]  dp;
    int lat;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       v = 20'($urandom_range(0, 999));
        1:       v = 20'($urandom_range(999990, 1048575));
        default: v = 20'($urandom_range(0, 1048575));
      endcase
      dp = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'b0;
      run_conv(v, dp, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency v=%0d got=%0d exp=%0d", i, v, lat, LAT); end
      checks++; if (bus.data !== model_data(v)) begin errors++; $display("FAIL rnd%0d_data v=%0d got=%h exp=%h", i, v, bus.data, model_data(v)); end
      checks++; if (bus.digit_enable !== model_en(v, dp)) begin errors++; $display("FAIL rnd%0d_en v=%0d dp=%b got=%b exp=%b", i, v, dp, bus.digit_enable, model_en(v, dp)); end
      checks++; if (bus.decimal_point_enable !== dp) begin errors++; $display("FAIL rnd%0d_dp got=%b exp=%b", i, bus.decimal_point_enable, dp); end
      checks++; if (bus.overflow !== (v > 999999)) begin errors++; $display("FAIL rnd%0d_ovf v=%0d got=%b exp=%b", i, v, bus.overflow, (v > 999999)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] a, b;
    int lowc, lat;
    a = 20'd314159;
    b = 20'd2718;
    for (int k = 0; k < 50 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    bus.in_value = a;
    bus.in_dp    = 6'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_value = b;
    lowc = 0;
    for (int k = 0; k < LAT; k++) begin
      if (!bus.in_ready) lowc++;
      @(posedge clk); #1;
    end
    checks++; if (lowc !== LAT) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=%0d", lowc, LAT); end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done rdy=%b ov=%b exp rdy=1 ov=1", bus.in_ready, bus.out_valid);
    end
    checks++; if (bus.data !== model_data(a)) begin errors++; $display("FAIL b2b_data_a got=%h exp=%h", bus.data, model_data(a)); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept rdy=%b ov=%b exp rdy=0 ov=0", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = k; break; end
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency_b got=%0d exp=%0d", lat, LAT); end
    checks++; if (bus.data !== model_data(b) || bus.digit_enable !== model_en(b, 6'b0)) begin
      errors++; $display("FAIL b2b_data_b got=%h/%b exp=%h/%b", bus.data, bus.digit_enable, model_data(b), model_en(b, 6'b0));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int k = 0; k < 50 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    bus.in_value = 20'd777;
    bus.in_dp    = 6'b000001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.data !== 24'h0 || bus.digit_enable !== 6'b0 || bus.decimal_point_enable !== 6'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs data=%h en=%b dp=%b ovf=%b exp all zero", bus.data, bus.digit_enable, bus.decimal_point_enable, bus.overflow);
    end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_handshake rdy=%b ov=%b exp rdy=1 ov=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0 || bus.data !== 24'h0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_no_update ov_count=%0d data=%h rdy=%b exp 0/000000/1", seen, bus.data, bus.in_ready);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset_n      = 1'b0;
    bus.in_value = '0;
    bus.in_dp    = '0;
    bus.in_valid = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_directed();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
